// File: rtl/oled_text_engine.sv
// rtl/oled_text_engine.sv - SSD1306 slot-table glyph renderer emitting 24-bit IIC words
// OLED_INVERT_EN: when defined, desc_data[19] selects per-slot reverse video on glyph bytes.
module oled_text_engine #(
    parameter int         SLOT_NUM = 16,
    parameter int         SLOT_W   = 4,
    parameter logic [7:0] I2C_ADDR = 8'h78
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SLOT_W:0]   num_slots,
    output logic [SLOT_W-1:0] desc_addr,
    input  logic [19:0]       desc_data,
    output logic [12:0]       font_addr,
    input  logic [7:0]        font_data,
    output logic              cmd_valid,
    output logic [23:0]       cmd_data,
    input  logic              write_done,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, DESC, FETCH, SEND, DONE} state_t;

    localparam logic [SLOT_W:0] SLOT_MAX = SLOT_NUM[SLOT_W:0];
    localparam logic [SLOT_W:0] SLOT_ONE = {{SLOT_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W:0]   cnt_q, cnt_d;
    logic [2:0]        page_q, page_d;
    logic [6:0]        col_q, col_d;
    logic [7:0]        glyph_q, glyph_d;
    logic              size_q, size_d;
    logic              row_q, row_d;
    logic [4:0]        word_q, word_d;
    logic [12:0]       font_addr_q, font_addr_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              is_data_q, is_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [SLOT_W:0]   clamp_cnt;
    logic [SLOT_W:0]   slot_nxt;
    logic [4:0]        last_word;
    logic [4:0]        widx;
    logic [2:0]        pg_row;
    logic              to_fetch;
    logic [7:0]        data_byte;

`ifdef OLED_INVERT_EN
    logic inv_q, inv_d;
    assign data_byte = inv_q ? ~font_data : font_data;
`else
    logic unused_inv;
    assign unused_inv = desc_data[19];
    assign data_byte  = font_data;
`endif

    assign clamp_cnt = (num_slots > SLOT_MAX) ? SLOT_MAX : num_slots;
    assign slot_nxt  = {1'b0, slot_q} + SLOT_ONE;
    assign last_word = size_q ? 5'd18 : 5'd10;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        page_d      = page_q;
        col_d       = col_q;
        glyph_d     = glyph_q;
        size_d      = size_q;
        row_d       = row_q;
        word_d      = word_q;
        font_addr_d = font_addr_q;
        cmd_byte_d  = cmd_byte_q;
        is_data_d   = is_data_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 1'b0;
        to_fetch    = 1'b0;
`ifdef OLED_INVERT_EN
        inv_d       = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = clamp_cnt;
                    slot_d  = '0;
                    state_d = (clamp_cnt == '0) ? DONE : DESC;
                    done_d  = (clamp_cnt == '0);
                end
            end
            DESC: begin
                page_d   = desc_data[17:15];
                col_d    = desc_data[14:8];
                glyph_d  = desc_data[7:0];
                size_d   = desc_data[18];
`ifdef OLED_INVERT_EN
                inv_d    = desc_data[19];
`endif
                row_d    = 1'b0;
                word_d   = 5'd0;
                to_fetch = 1'b1;
                state_d  = FETCH;
            end
            FETCH: begin
                cmd_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (write_done) begin
                    cmd_valid_d = 1'b0;
                    if (word_q != last_word) begin
                        word_d   = word_q + 5'd1;
                        to_fetch = 1'b1;
                        state_d  = FETCH;
                    end else if (!row_q) begin
                        row_d    = 1'b1;
                        word_d   = 5'd0;
                        to_fetch = 1'b1;
                        state_d  = FETCH;
                    end else if (slot_nxt < cnt_q) begin
                        slot_d  = slot_nxt[SLOT_W-1:0];
                        state_d = DESC;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Word setup happens on entry to FETCH so font_addr is stable a full cycle before data is used.
        widx   = word_d - 5'd3;
        pg_row = page_d + {2'b00, row_d};
        if (to_fetch) begin
            is_data_d = (word_d >= 5'd3);
            case (word_d)
                5'd0:    cmd_byte_d = {5'b10110, pg_row};
                5'd1:    cmd_byte_d = {4'h0, col_d[3:0]};
                default: cmd_byte_d = {5'b00010, col_d[6:4]};
            endcase
            if (word_d >= 5'd3) begin
                font_addr_d = {glyph_d, row_d, widx[3:0]};
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            page_q      <= '0;
            col_q       <= '0;
            glyph_q     <= '0;
            size_q      <= 1'b0;
            row_q       <= 1'b0;
            word_q      <= '0;
            font_addr_q <= '0;
            cmd_byte_q  <= '0;
            is_data_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef OLED_INVERT_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            page_q      <= page_d;
            col_q       <= col_d;
            glyph_q     <= glyph_d;
            size_q      <= size_d;
            row_q       <= row_d;
            word_q      <= word_d;
            font_addr_q <= font_addr_d;
            cmd_byte_q  <= cmd_byte_d;
            is_data_q   <= is_data_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef OLED_INVERT_EN
            inv_q       <= inv_d;
`endif
        end
    end

    // Data words pass the ROM byte straight through; it is stable because font_addr is held.
    assign cmd_data  = cmd_valid_q ? {I2C_ADDR, (is_data_q ? 8'h40 : 8'h00),
                                      (is_data_q ? data_byte : cmd_byte_q)} : 24'h0;
    assign desc_addr = slot_q;
    assign font_addr = font_addr_q;
    assign cmd_valid = cmd_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_oled_text_engine.sv
// tb/tb_oled_text_engine.sv - directed self-checking bench for oled_text_engine
module tb_oled_text_engine;
    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  num_slots;
    logic [3:0]  desc_addr;
    logic [19:0] desc_data;
    logic [12:0] font_addr;
    logic [7:0]  font_data;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        write_done;
    logic        busy;
    logic        done;

    oled_text_engine dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .num_slots(num_slots),
        .desc_addr(desc_addr), .desc_data(desc_data), .font_addr(font_addr),
        .font_data(font_data), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .write_done(write_done), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc;
    int busy_fall;
    int busy_rise;
    int stable_err;
    logic prev_valid = 1'b0;
    logic prev_busy = 1'b0;

    logic [19:0] desc_mem [16];
    logic [23:0] word_q [$];
    logic [12:0] fa_q [$];
    int          wd_q [$];
    int          rise_q [$];
    int          done_q [$];
    logic [23:0] exp_data [$];
    logic [12:0] exp_fa [$];
    bit          exp_isd [$];

    assign desc_data = desc_mem[desc_addr];

    function automatic logic [7:0] rom_byte(input logic [12:0] a);
        return (a[12:5] == 8'h7E) ? 8'h3C : (a[7:0] ^ 8'hA5);
    endfunction

    always @(posedge sys_clk) begin
        cyc++;
        font_data <= rom_byte(font_addr);
    end

    always @(negedge sys_clk) begin
        if (cmd_valid && !prev_valid) rise_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (prev_busy && !busy) busy_fall = cyc;
        if (!prev_busy && busy) busy_rise = cyc;
        prev_valid = cmd_valid;
        prev_busy  = busy;
    end

    // IIC writer model: acknowledges each word on the fourth cycle it is presented.
    initial begin
        int wcnt;
        logic [23:0] first_data;
        wcnt = 0;
        first_data = '0;
        write_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            write_done = 1'b0;
            if (cmd_valid) begin
                if (wcnt == 0) first_data = cmd_data;
                if (wcnt == 3) begin
                    write_done = 1'b1;
                    wd_q.push_back(cyc);
                    word_q.push_back(cmd_data);
                    fa_q.push_back(font_addr);
                    if (cmd_data !== first_data) stable_err++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        word_q.delete(); fa_q.delete(); wd_q.delete(); rise_q.delete(); done_q.delete();
        stable_err = 0; busy_fall = -1; busy_rise = -1;
    endtask

    task automatic build_exp(input int n);
        int ns, w;
        logic [19:0] d;
        logic [2:0]  pg;
        logic [12:0] fa;
        logic [7:0]  b;
        exp_data.delete(); exp_fa.delete(); exp_isd.delete();
        ns = (n > 16) ? 16 : n;
        for (int s = 0; s < ns; s++) begin
            d = desc_mem[s];
            w = d[18] ? 16 : 8;
            for (int r = 0; r < 2; r++) begin
                pg = d[17:15] + 3'(r);
                exp_data.push_back({8'h78, 8'h00, 5'b10110, pg});          exp_fa.push_back('0); exp_isd.push_back(0);
                exp_data.push_back({8'h78, 8'h00, 4'h0, d[11:8]});        exp_fa.push_back('0); exp_isd.push_back(0);
                exp_data.push_back({8'h78, 8'h00, 5'b00010, d[14:12]});   exp_fa.push_back('0); exp_isd.push_back(0);
                for (int bi = 0; bi < w; bi++) begin
                    fa = {d[7:0], 1'(r), 4'(bi)};
                    b  = rom_byte(fa);
`ifdef OLED_INVERT_EN
                    if (d[19]) b = ~b;
`endif
                    exp_data.push_back({8'h78, 8'h40, b}); exp_fa.push_back(fa); exp_isd.push_back(1);
                end
            end
        end
    endtask

    task automatic run_pass(input int n, input int restart_at);
        bit got;
        clear_logs();
        @(negedge sys_clk);
        start = 1'b1; num_slots = 5'(n); start_cyc = cyc;
        got = 0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge sys_clk); #1;
            start = (restart_at != 0 && i == restart_at);
            if (done_q.size() > 0) got = 1;
        end
        start = 1'b0;
        if (!got) check("timeout_done", 0, 1);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic compare_pass(input string name);
        check({name, "_count"}, word_q.size(), exp_data.size());
        for (int i = 0; i < word_q.size() && i < exp_data.size(); i++) begin
            check($sformatf("%s_word%0d", name, i), word_q[i], exp_data[i]);
            if (exp_isd[i]) check($sformatf("%s_faddr%0d", name, i), fa_q[i], exp_fa[i]);
        end
        check({name, "_stable"}, stable_err, 0);
        check({name, "_done_cnt"}, done_q.size(), 1);
    endtask

    initial begin
        bit got;
        logic [7:0] exp_b;
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        logic [7:0] exp_b;
        rst_n = 1'b0; start = 1'b0; num_slots = '0;
        for (int i = 0; i < 16; i++) desc_mem[i] = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_ctl", {cmd_valid, busy, done, desc_addr}, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_font_addr", font_addr, 0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("idle_busy", busy, 0);

        // One 8x16 slot
        desc_mem[0] = {1'b0, 1'b0, 3'd2, 7'h35, 8'h41};
        build_exp(1);
        run_pass(1, 0);
        compare_pass("one");
        check("one_w0", word_q[0], 24'h7800B2);
        check("one_w1", word_q[1], 24'h780005);
        check("one_w2", word_q[2], 24'h780013);
        check("one_w11", word_q[11], 24'h7800B3);
        check("one_fa_first", fa_q[3], 13'h820);
        check("one_fa_r0_last", fa_q[10], 13'h827);
        check("one_fa_r1_first", fa_q[14], 13'h830);
        check("one_fa_r1_last", fa_q[21], 13'h837);
        check("one_busy_rise", busy_rise - start_cyc, 1);
        check("one_first_valid", rise_q[0] - start_cyc, 3);

        // 16x16 then 8x16
        desc_mem[0] = {1'b0, 1'b1, 3'd0, 7'h10, 8'h22};
        desc_mem[1] = {1'b0, 1'b0, 3'd4, 7'h60, 8'h05};
        build_exp(2);
        run_pass(2, 0);
        compare_pass("two");
        check("two_gap_in_slot", rise_q[1] - wd_q[0], 2);
        check("two_gap_slot_change", rise_q[38] - wd_q[37], 3);
        check("two_done_lat", done_q[0] - wd_q[59], 1);
        check("two_busy_fall", busy_fall - wd_q[59], 2);

        // Zero slots
        run_pass(0, 0);
        check("zero_words", rise_q.size(), 0);
        check("zero_done_cnt", done_q.size(), 1);
        check("zero_done_lat", done_q[0] - start_cyc, 1);

        // Clamp 20 -> 16 slots, mixed sizes
        for (int i = 0; i < 16; i++)
            desc_mem[i] = {1'b0, i[0], i[2:0], 7'(i * 9), 8'(8'h30 + i)};
        build_exp(20);
        run_pass(20, 0);
        check("clamp_total", word_q.size(), 480);
        compare_pass("clamp");

        // Page wrap, inversion, and a start while busy
        desc_mem[0] = {1'b1, 1'b0, 3'd7, 7'h02, 8'h7E};
        build_exp(1);
        run_pass(1, 40);
        compare_pass("wrap");
        check("wrap_row0_page", word_q[0], 24'h7800B7);
        check("wrap_row1_page", word_q[11], 24'h7800B0);
`ifdef OLED_INVERT_EN
        exp_b = 8'hC3;
`else
        exp_b = 8'h3C;
`endif
        check("inv_data_byte", word_q[3], {8'h78, 8'h40, exp_b});

        // Reset during the 10th word
        desc_mem[0] = {1'b0, 1'b0, 3'd2, 7'h35, 8'h41};
        desc_mem[1] = {1'b0, 1'b1, 3'd5, 7'h44, 8'h10};
        clear_logs();
        @(negedge sys_clk);
        start = 1'b1; num_slots = 5'd2;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge sys_clk); #1;
            start = 1'b0;
            if (word_q.size() == 9 && cmd_valid) got = 1;
        end
        check("abort_reach_word10", got, 1);
        rst_n = 1'b0;
        #1;
        check("abort_ctl", {cmd_valid, busy, done, desc_addr}, 0);
        check("abort_cmd_data", cmd_data, 0);
        check("abort_font_addr", font_addr, 0);
        repeat (3) @(negedge sys_clk);
        check("abort_no_done", done_q.size(), 0);
        rst_n = 1'b1;
        build_exp(2);
        run_pass(2, 0);
        compare_pass("restart");
        check("restart_w0", word_q[0], 24'h7800B2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
